// File: rtl/fifo_stream_buffer_if.sv
// fifo_stream_buffer_if: valid/ready stream bundle for the FIFO's write and read ports
interface fifo_stream_buffer_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fifo_stream_buffer.sv
// fifo_stream_buffer: synchronous FWFT FIFO with valid/ready ports, registered status flags and flush
module fifo_stream_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    fifo_stream_buffer_if.slave   s,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count_nxt;
    logic                  push, pop, clr;
    assign s.in_ready  = !full;
    assign s.out_valid = !empty;
    assign s.out_data  = mem[rd_ptr];
    assign push = s.in_valid && s.in_ready;
    assign pop  = s.out_valid && s.out_ready;
    assign clr  = rst || flush;
    // next occupancy; flags below are derived from it so they line up with count
    always_comb count_nxt = clr ? '0 : count + CW'(push) - CW'(pop);
    // storage write, suppressed when the cycle's word is being discarded
    always_ff @(posedge clk) if (push && !clr) mem[wr_ptr] <= s.in_data;
    // pointers, occupancy and registered status flags
    always_ff @(posedge clk) begin
        wr_ptr       <= clr ? '0 : !push ? wr_ptr : wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
        rd_ptr       <= clr ? '0 : !pop ? rd_ptr : rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
        count        <= count_nxt;
        full         <= count_nxt == CW'(DEPTH);
        empty        <= count_nxt == '0;
        almost_full  <= count_nxt >= CW'(AF_LEVEL);
        almost_empty <= count_nxt <= CW'(AE_LEVEL);
    end
endmodule

// File: tb/tb_fifo_stream_buffer.sv
// tb_fifo_stream_buffer: directed self-checking bench for fifo_stream_buffer (DEPTH 8)
module tb_fifo_stream_buffer;
    logic       clk = 0;
    logic       rst, flush;
    logic [3:0] count;
    logic       full, empty, almost_full, almost_empty;
    int         passed = 0, total = 0;

    fifo_stream_buffer_if #(.DATA_WIDTH(16)) bus ();

    fifo_stream_buffer #(.DATA_WIDTH(16), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .flush(flush), .s(bus),
        .count(count), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d);
        bus.in_valid = 1;
        bus.in_data  = d;
        step();
        bus.in_valid = 0;
    endtask

    task automatic pop_chk(input logic [15:0] exp);
        chk("pop_valid", 32'(bus.out_valid), 1);
        chk("pop_data", 32'(bus.out_data), 32'(exp));
        bus.out_ready = 1;
        step();
        bus.out_ready = 0;
    endtask

    initial begin
        rst = 1; flush = 0;
        bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0;
        step();
        rst = 0;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_ae", 32'(almost_empty), 1);
        chk("rst_af", 32'(almost_full), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_valid", 32'(bus.out_valid), 0);

        // fill to full
        for (int i = 1; i <= 8; i++) begin
            push(16'(i));
            chk("fill_count", 32'(count), 32'(i));
            chk("fill_af", 32'(almost_full), 32'(i >= 6));
            chk("fill_ae", 32'(almost_empty), 32'(i <= 2));
            chk("fill_full", 32'(full), 32'(i == 8));
            chk("fill_in_ready", 32'(bus.in_ready), 32'(i != 8));
        end

        // drain in order
        for (int i = 1; i <= 8; i++) begin
            pop_chk(16'(i));
            chk("drain_count", 32'(count), 32'(8 - i));
            chk("drain_ae", 32'(almost_empty), 32'(8 - i <= 2));
            chk("drain_empty", 32'(empty), 32'(i == 8));
        end
        chk("drain_out_valid", 32'(bus.out_valid), 0);

        // wrap-around
        for (int i = 0; i < 5; i++) push(16'h0010 + 16'(i));
        for (int i = 0; i < 5; i++) pop_chk(16'h0010 + 16'(i));
        for (int i = 0; i < 6; i++) push(16'h00A0 + 16'(i));
        chk("wrap_count", 32'(count), 6);
        chk("wrap_af", 32'(almost_full), 1);
        for (int i = 0; i < 6; i++) pop_chk(16'h00A0 + 16'(i));
        chk("wrap_empty", 32'(empty), 1);

        // simultaneous push/pop at count 4
        for (int i = 0; i < 4; i++) push(16'h00B0 + 16'(i));
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1; bus.in_data = 16'h00C0 + 16'(i); bus.out_ready = 1;
            chk("pp_data", 32'(bus.out_data), i < 4 ? 32'h00B0 + 32'(i) : 32'h00C0 + 32'(i - 4));
            step();
            chk("pp_count", 32'(count), 4);
        end
        bus.in_valid = 0; bus.out_ready = 0;
        for (int i = 6; i < 10; i++) pop_chk(16'h00C0 + 16'(i));
        chk("pp_empty", 32'(empty), 1);

        // full with in_valid and out_ready
        for (int i = 0; i < 8; i++) push(16'h00D0 + 16'(i));
        bus.in_valid = 1; bus.in_data = 16'h00EE; bus.out_ready = 1;
        chk("fullpp_in_ready", 32'(bus.in_ready), 0);
        step();
        chk("fullpp_count", 32'(count), 7);
        chk("fullpp_full", 32'(full), 0);
        bus.out_ready = 0;
        step();
        bus.in_valid = 0;
        chk("fullpp_refill", 32'(count), 8);
        for (int i = 1; i < 8; i++) pop_chk(16'h00D0 + 16'(i));
        pop_chk(16'h00EE);
        chk("fullpp_empty", 32'(empty), 1);

        // push into empty with out_ready high: no same-cycle pop
        bus.in_valid = 1; bus.in_data = 16'h0055; bus.out_ready = 1;
        chk("ep_valid_before", 32'(bus.out_valid), 0);
        step();
        bus.in_valid = 0;
        chk("ep_count", 32'(count), 1);
        chk("ep_valid", 32'(bus.out_valid), 1);
        chk("ep_data", 32'(bus.out_data), 32'h0055);
        step();
        bus.out_ready = 0;
        chk("ep_popped", 32'(count), 0);

        // flush with concurrent push
        for (int i = 0; i < 5; i++) push(16'h00F0 + 16'(i));
        chk("fl_pre", 32'(count), 5);
        flush = 1; bus.in_valid = 1; bus.in_data = 16'h0099;
        step();
        flush = 0; bus.in_valid = 0;
        chk("fl_count", 32'(count), 0);
        chk("fl_empty", 32'(empty), 1);
        chk("fl_out_valid", 32'(bus.out_valid), 0);
        push(16'h1234);
        chk("fl_after_count", 32'(count), 1);
        pop_chk(16'h1234);

        // reset mid-operation
        for (int i = 0; i < 3; i++) push(16'h0070 + 16'(i));
        chk("rs_pre", 32'(count), 3);
        rst = 1;
        step();
        rst = 0;
        chk("rs_count", 32'(count), 0);
        chk("rs_out_valid", 32'(bus.out_valid), 0);
        chk("rs_in_ready", 32'(bus.in_ready), 1);
        push(16'h4321);
        pop_chk(16'h4321);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
